// File: rtl/spawn_pkg.sv
// Shared types and constants for the spawn scheduler slice.
package spawn_pkg;

  localparam int unsigned RAND_W   = 4;
  localparam int unsigned RAND_MAX = 9;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SKIP_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    ROLL,
    SETTLE,
    LOAD,
    WAIT,
    REQ,
    NEXT
  } sched_state_t;

  // Random bank digits are nominally 0..9; anything larger is treated as 9.
  function automatic logic [RAND_W-1:0] clamp_rnd(input logic [RAND_W-1:0] v);
    return (v > RAND_W'(RAND_MAX)) ? RAND_W'(RAND_MAX) : v;
  endfunction

endpackage

// File: rtl/spawn_delay_counter.sv
// Frame-delay down-counter: loaded once per turn, decremented on frame ticks.
module spawn_delay_counter
  import spawn_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/spawn_scheduler.sv
// Rolls the random bank, latches a draw and issues timed round-robin spawn requests.
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int unsigned NUMBERS    = 3,
  parameter int unsigned MIN_FRAMES = 8,
  parameter int unsigned FRAME_STEP = 4
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic                      startOfFrame,
  input  logic [NUMBERS*RAND_W-1:0] randomNumbers,
  input  logic [NUMBERS-1:0]        slotBusy,
  input  logic [NUMBERS-1:0]        spawnAck,
  output logic                      randTrigger,
  output logic [NUMBERS-1:0]        spawnReq,
  output logic [RAND_W-1:0]         spawnParam,
  output logic [SKIP_W-1:0]         skipCount
);

  localparam int unsigned SLOT_W = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;

  sched_state_t state, state_d;

  logic [SLOT_W-1:0]              slot, slot_d, slot_inc;
  logic                           settle_cnt, settle_d;
  logic [RAND_W-1:0]              param_reg, param_d, spawn_param_d;
  logic                           rand_trig_d;
  logic [NUMBERS-1:0]             spawn_req_d, slot_onehot;
  logic [SKIP_W-1:0]              skip_d, skip_inc;
  logic [NUMBERS-1:0][RAND_W-1:0] rnd_arr;
  logic [RAND_W-1:0]              rnd_cur;
  logic [CNT_W-1:0]               delay_val;
  logic                           cnt_load_c, cnt_tick_c, cnt_zero_c;

  // Slot arithmetic, saturating skip increment and delay computation.
  assign rnd_arr     = randomNumbers;
  assign slot_inc    = (slot == SLOT_W'(NUMBERS - 1)) ? '0 : slot + SLOT_W'(1);
  assign slot_onehot = NUMBERS'(1) << slot;
  assign skip_inc    = (skipCount == '1) ? skipCount : skipCount + SKIP_W'(1);
  assign rnd_cur     = clamp_rnd(rnd_arr[slot]);
  assign delay_val   = CNT_W'(MIN_FRAMES + FRAME_STEP * 32'(rnd_cur));

  spawn_delay_counter u_delay (
    .clk      (clk),
    .resetN   (resetN),
    .load     (cnt_load_c),
    .load_val (delay_val),
    .tick     (cnt_tick_c),
    .zero_c   (cnt_zero_c)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    state_d       = state;
    slot_d        = slot;
    settle_d      = settle_cnt;
    param_d       = param_reg;
    skip_d        = skipCount;
    spawn_param_d = spawnParam;
    rand_trig_d   = 1'b0;
    spawn_req_d   = '0;
    cnt_load_c    = 1'b0;
    cnt_tick_c    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_d = ROLL;
        end
        ROLL: begin
          settle_d = 1'b0;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt) begin
            state_d = LOAD;
          end else begin
            settle_d = 1'b1;
          end
        end
        LOAD: begin
          cnt_load_c = 1'b1;
          param_d    = rnd_arr[slot_inc];
          state_d    = WAIT;
        end
        WAIT: begin
          if (cnt_zero_c) begin
            if (slotBusy[slot]) begin
              skip_d  = skip_inc;
              state_d = NEXT;
            end else begin
              state_d = REQ;
            end
          end else begin
            cnt_tick_c = startOfFrame;
          end
        end
        REQ: begin
          // Ack beats a simultaneous busy: the object was accepted.
          if (spawnAck[slot]) begin
            state_d = NEXT;
          end else if (slotBusy[slot]) begin
            skip_d  = skip_inc;
            state_d = NEXT;
          end
        end
        NEXT: begin
          slot_d  = slot_inc;
          state_d = ROLL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    rand_trig_d = (state_d == ROLL);
    if (state_d == REQ) begin
      spawn_req_d   = slot_onehot;
      spawn_param_d = param_reg;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slot        <= '0;
      settle_cnt  <= 1'b0;
      param_reg   <= '0;
      randTrigger <= 1'b0;
      spawnReq    <= '0;
      spawnParam  <= '0;
      skipCount   <= '0;
    end else begin
      slot        <= slot_d;
      settle_cnt  <= settle_d;
      param_reg   <= param_d;
      randTrigger <= rand_trig_d;
      spawnReq    <= spawn_req_d;
      spawnParam  <= spawn_param_d;
      skipCount   <= skip_d;
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with a turn-level reference model.
module tb_spawn_scheduler;

  localparam int N     = 3;
  localparam int MINF  = 8;
  localparam int STEPF = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        enable = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [11:0] randomNumbers = 12'h153;
  logic [2:0]  slotBusy = 3'b000;
  logic [2:0]  spawnAck = 3'b000;
  logic        randTrigger;
  logic [2:0]  spawnReq;
  logic [3:0]  spawnParam;
  logic [7:0]  skipCount;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  bit chk_en = 1'b0;

  spawn_scheduler #(.NUMBERS(N), .MIN_FRAMES(MINF), .FRAME_STEP(STEPF)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .enable        (enable),
    .startOfFrame  (startOfFrame),
    .randomNumbers (randomNumbers),
    .slotBusy      (slotBusy),
    .spawnAck      (spawnAck),
    .randTrigger   (randTrigger),
    .spawnReq      (spawnReq),
    .spawnParam    (spawnParam),
    .skipCount     (skipCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- reference model: one turn = trigger, settle, draw, frame delay, offer
  bit m_on = 0, m_trig = 0, m_req = 0, m_adv = 0;
  int m_slot = 0, m_skip = 0, m_age = 0, m_frames = 0, m_param_lat = 0, m_param_out = 0;

  function automatic int rnd_of(input int i);
    logic [11:0] v;
    v = randomNumbers >> (4 * i);
    return int'(v[3:0]);
  endfunction

  task automatic start_turn();
    m_on   = 1;
    m_age  = 0;
    m_trig = 1;
    m_adv  = 0;
  endtask

  task automatic bump_skip();
    if (m_skip < 255) m_skip = m_skip + 1;
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_on = 0; m_trig = 0; m_req = 0; m_adv = 0;
      m_slot = 0; m_skip = 0; m_age = 0; m_frames = 0; m_param_out = 0;
    end else if (!enable) begin
      m_on = 0; m_trig = 0; m_req = 0; m_adv = 0;
    end else if (!m_on) begin
      start_turn();
    end else begin
      m_trig = 0;
      if (m_adv) begin
        m_slot = (m_slot + 1) % N;
        start_turn();
      end else if (m_req) begin
        if (spawnAck[m_slot]) begin
          m_req = 0; m_adv = 1;
        end else if (slotBusy[m_slot]) begin
          m_req = 0; m_adv = 1; bump_skip();
        end
      end else if (m_age < 3) begin
        m_age = m_age + 1;
      end else if (m_age == 3) begin
        m_frames    = MINF + STEPF * ((rnd_of(m_slot) > 9) ? 9 : rnd_of(m_slot));
        m_param_lat = rnd_of((m_slot + 1) % N);
        m_age       = 4;
      end else if (m_frames > 0) begin
        m_frames = m_frames - int'(startOfFrame);
      end else if (slotBusy[m_slot]) begin
        bump_skip(); m_adv = 1;
      end else begin
        m_req = 1; m_param_out = m_param_lat;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model, plus trigger pulse counting.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_trig", 32'(randTrigger), 32'(m_trig));
      check("cyc_req", 32'(spawnReq), m_req ? (32'd1 << m_slot) : 32'd0);
      check("cyc_skip", 32'(skipCount), 32'(m_skip));
      if (m_req) check("cyc_param", 32'(spawnParam), 32'(m_param_out));
    end
    if (randTrigger === 1'b1) trig_cnt++;
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic wait_req(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (spawnReq != 3'b000) return;
      step();
    end
    timeout(name);
  endtask

  task automatic wait_trig(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (randTrigger) return;
      step();
    end
    timeout(name);
  endtask

  task automatic serve(input string name, input int s, input int p);
    logic [2:0] oh;
    oh = 3'(1 << s);
    startOfFrame = 1'b1;
    wait_req(name, 400);
    check({name, "_req"}, 32'(spawnReq), 32'(oh));
    check({name, "_param"}, 32'(spawnParam), 32'(p));
    spawnAck = oh;
    step();
    spawnAck = 3'b000;
    startOfFrame = 1'b0;
  endtask

  initial begin
    bit req_seen;

    // Reset values
    #2 resetN = 1'b0;
    #1;
    check("rst_trig", 32'(randTrigger), 32'd0);
    check("rst_req", 32'(spawnReq), 32'd0);
    check("rst_param", 32'(spawnParam), 32'd0);
    check("rst_skip", 32'(skipCount), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    chk_en = 1'b1;

    // 1) slot 0 delay 8+3*4=20 frames, param = rnd[1] = 5
    enable = 1'b1;
    step();
    check("t1_trig", 32'(randTrigger), 32'd1);
    step();
    check("t1_trig_width", 32'(randTrigger), 32'd0);
    repeat (3) step();
    pulse_frames(19);
    check("t1_no_req_19", 32'(spawnReq), 32'd0);
    pulse_frames(1);
    check("t1_req_20", 32'(spawnReq), 32'b001);
    check("t1_param", 32'(spawnParam), 32'd5);
    trig_cnt = 0;
    spawnAck = 3'b001;
    step();
    spawnAck = 3'b000;
    check("t1_req_drop", 32'(spawnReq), 32'd0);
    step();
    check("t1_next_trig", 32'(randTrigger), 32'd1);

    // 2) full round: slots 1,2,0 with params rnd[2]=1, rnd[0]=3, rnd[1]=5
    serve("t2_s1", 1, 1);
    serve("t2_s2", 2, 3);
    serve("t2_s0", 0, 5);
    check("t2_trig_per_turn", 32'(trig_cnt), 32'd3);

    // 3) slot 1 busy at expiry: skipped, then slot 2 served
    slotBusy = 3'b010;
    startOfFrame = 1'b1;
    req_seen = 1'b0;
    for (int i = 0; i < 400 && skipCount == 8'd0; i++) begin
      if (spawnReq != 3'b000) req_seen = 1'b1;
      step();
    end
    check("t3_skip", 32'(skipCount), 32'd1);
    check("t3_no_req", 32'(req_seen), 32'd0);
    slotBusy = 3'b000;
    serve("t3_s2", 2, 3);

    // 4) ack and busy together count as spawn; busy alone withdraws
    startOfFrame = 1'b1;
    wait_req("t4_wait0", 400);
    check("t4_req0", 32'(spawnReq), 32'b001);
    spawnAck = 3'b001;
    slotBusy = 3'b001;
    step();
    spawnAck = 3'b000;
    slotBusy = 3'b000;
    check("t4_ack_wins_req", 32'(spawnReq), 32'd0);
    check("t4_ack_wins_skip", 32'(skipCount), 32'd1);
    wait_req("t4_wait1", 400);
    check("t4_req1", 32'(spawnReq), 32'b010);
    slotBusy = 3'b010;
    step();
    slotBusy = 3'b000;
    check("t4_withdraw_req", 32'(spawnReq), 32'd0);
    check("t4_withdraw_skip", 32'(skipCount), 32'd2);

    // 5) abort in WAIT and in REQ; slot is kept across the abort
    wait_trig("t5_trig_wait", 100);
    repeat (8) step();
    enable = 1'b0;
    step();
    check("t5_wait_abort_req", 32'(spawnReq), 32'd0);
    check("t5_wait_abort_trig", 32'(randTrigger), 32'd0);
    step();
    enable = 1'b1;
    step();
    check("t5_restart_trig", 32'(randTrigger), 32'd1);
    wait_req("t5_wait_req", 400);
    check("t5_req_slot2", 32'(spawnReq), 32'b100);
    enable = 1'b0;
    step();
    check("t5_req_abort", 32'(spawnReq), 32'd0);
    enable = 1'b1;
    serve("t5_s2", 2, 3);
    startOfFrame = 1'b1;
    wait_trig("t5_trig_s0", 100);
    repeat (8) step();
    resetN = 1'b0;
    #1;
    check("t5_arst_trig", 32'(randTrigger), 32'd0);
    check("t5_arst_req", 32'(spawnReq), 32'd0);
    check("t5_arst_param", 32'(spawnParam), 32'd0);
    check("t5_arst_skip", 32'(skipCount), 32'd0);
    enable = 1'b0;
    startOfFrame = 1'b0;
    step();
    step();
    resetN = 1'b1;

    // 6) rnd=15 clamps to 9: delay 8+9*4=44 frames
    randomNumbers = 12'h15F;
    enable = 1'b1;
    step();
    check("t6_trig", 32'(randTrigger), 32'd1);
    repeat (4) step();
    pulse_frames(43);
    check("t6_no_req_43", 32'(spawnReq), 32'd0);
    pulse_frames(1);
    check("t6_req_44", 32'(spawnReq), 32'b001);
    check("t6_param", 32'(spawnParam), 32'd5);
    spawnAck = 3'b001;
    step();
    spawnAck = 3'b000;

    // 6b) every slot busy: skipCount saturates at 255
    randomNumbers = 12'h000;
    slotBusy = 3'b111;
    startOfFrame = 1'b1;
    for (int i = 0; i < 6000 && skipCount != 8'd255; i++) step();
    check("t6_skip_reach", 32'(skipCount), 32'd255);
    repeat (60) step();
    check("t6_skip_sat", 32'(skipCount), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
